riscv_mem_banked: RTL and testbench

Byte-addressable unified instruction/data memory for the kana-riscv core. It replaces the combinational single-array RAM with a banked, synchronous-read memory. The instruction port has fixed latency. The data port uses a req/ready and valid/ready handshake with a configurable read latency, load sign/zero extension, and misalignment and out-of-range error reporting. It sits between the core's fetch/LSU stages and the on-chip BRAM, and infers one BRAM per byte lane.

---
 rtl/riscv_pkg.sv | 50 +++++
 rtl/riscv_bram_lane.sv | 36 +++
 rtl/riscv_mem_banked.sv | 156 +++++++++++++++
 tb/tb_riscv_mem_banked.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared kana-riscv definitions: access-size select, memory FSM states and
// helpers for byte-lane enables and load extension.
package riscv_pkg;

    localparam int unsigned MAX_WORD  = 64;
    localparam int unsigned MAX_LANES = MAX_WORD / 8;
    localparam int unsigned LSB_BITS  = $clog2(MAX_LANES);

    typedef enum logic [1:0] {
        MASK_B = 2'd0,
        MASK_H = 2'd1,
        MASK_X = 2'd2
    } MASK_SEL;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } MEM_STATE;

    function automatic logic [MAX_LANES-1:0] byte_enable(input MASK_SEL mask,
                                                         input logic [LSB_BITS-1:0] addr_lsb);
        logic [MAX_LANES-1:0] be;
        case (mask)
            MASK_B:  be = MAX_LANES'(1) << addr_lsb;
            MASK_H:  be = MAX_LANES'(3) << addr_lsb;
            default: be = '1;
        endcase
        return be;
    endfunction

    // Result is sized for the widest word; callers truncate to their width.
    function automatic logic [MAX_WORD-1:0] load_extend(input logic [MAX_WORD-1:0] word,
                                                        input MASK_SEL mask,
                                                        input logic [LSB_BITS-1:0] addr_lsb,
                                                        input logic is_unsigned);
        logic [7:0]          lane_b;
        logic [15:0]         lane_h;
        logic [MAX_WORD-1:0] ext;
        lane_b = 8'(word >> {addr_lsb, 3'b000});
        lane_h = 16'(word >> {addr_lsb, 3'b000});
        case (mask)
            MASK_B:  ext = {{(MAX_WORD-8){~is_unsigned & lane_b[7]}}, lane_b};
            MASK_H:  ext = {{(MAX_WORD-16){~is_unsigned & lane_h[15]}}, lane_h};
            default: ext = word;
        endcase
        return ext;
    endfunction

endpackage

// File: rtl/riscv_bram_lane.sv
// One byte lane of the unified memory: dual-port 8-bit synchronous RAM,
// port A read-only for fetch, port B read/write for the data port.
module riscv_bram_lane #(
    parameter int unsigned DEPTH  = 4096,
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              a_en,
    input  logic [ADDR_W-1:0] a_addr,
    output logic [7:0]        a_rdata,
    input  logic              b_en,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [7:0]        b_wdata,
    output logic [7:0]        b_rdata
);

    logic [7:0] mem [DEPTH];

    // Both ports are read-first: a same-edge write is not visible until the next read.
    always_ff @(posedge clk) begin
        if (a_en) begin
            a_rdata <= mem[a_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (b_en) begin
            if (b_we) begin
                mem[b_addr] <= b_wdata;
            end
            b_rdata <= mem[b_addr];
        end
    end

endmodule

// File: rtl/riscv_mem_banked.sv
// Banked unified instruction/data memory: fixed-latency fetch port and a
// handshaked data port with configurable read latency and error reporting.
module riscv_mem_banked
    import riscv_pkg::*;
#(
    parameter int unsigned WORD_LENGTH  = 32,
    parameter int unsigned ADDR_LENGTH  = 32,
    parameter int unsigned NUM_MEM      = 16384,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_req,
    input  logic [ADDR_LENGTH-1:0] i_addr,
    output logic                   i_rvalid,
    output logic [WORD_LENGTH-1:0] i_inst,
    output logic                   i_err,
    input  logic                   d_req,
    output logic                   d_ready,
    input  logic                   d_we,
    input  logic [ADDR_LENGTH-1:0] d_addr,
    input  logic [WORD_LENGTH-1:0] d_wdata,
    input  MASK_SEL                d_mask,
    input  logic                   d_unsigned,
    output logic                   d_rvalid,
    input  logic                   d_rready,
    output logic [WORD_LENGTH-1:0] d_rdata,
    output logic                   d_err
);

    localparam int unsigned NUM_BANKS = WORD_LENGTH / 8;
    localparam int unsigned BANK_BITS = $clog2(NUM_BANKS);
    localparam int unsigned DEPTH     = NUM_MEM / NUM_BANKS;
    localparam int unsigned ROW_BITS  = $clog2(DEPTH);
    localparam int unsigned MEM_BITS  = $clog2(NUM_MEM);
    localparam logic [ADDR_LENGTH:0] MEM_LIMIT = (ADDR_LENGTH+1)'(NUM_MEM);

    logic                   i_bad, d_mis, d_bad, accept;
    logic [ROW_BITS-1:0]    i_row, d_row;
    logic [NUM_BANKS-1:0]   lane_en;
    logic [WORD_LENGTH-1:0] wdata_rep, a_word, b_word, rdata_ext;

    MEM_STATE               state;
    logic                   i_rvalid_q, i_err_q;
    logic                   d_ready_q, d_rvalid_q, d_err_q, load_q, uns_q;
    MASK_SEL                mask_q;
    logic [BANK_BITS-1:0]   lsb_q;
    logic [WORD_LENGTH-1:0] rdata_q;

    assign accept = d_req && d_ready_q;
    assign i_row  = i_addr[MEM_BITS-1:BANK_BITS];
    assign d_row  = d_addr[MEM_BITS-1:BANK_BITS];
    assign i_bad  = (|i_addr[BANK_BITS-1:0]) || ({1'b0, i_addr} >= MEM_LIMIT);
    assign d_bad  = d_mis || ({1'b0, d_addr} >= MEM_LIMIT);

    always_comb begin
        d_mis     = 1'b0;
        wdata_rep = d_wdata;
        case (d_mask)
            MASK_B: wdata_rep = {NUM_BANKS{d_wdata[7:0]}};
            MASK_H: begin
                d_mis     = d_addr[0];
                wdata_rep = {(NUM_BANKS/2){d_wdata[15:0]}};
            end
            default: d_mis = |d_addr[BANK_BITS-1:0];
        endcase
    end

    assign lane_en   = NUM_BANKS'(byte_enable(d_mask, LSB_BITS'(d_addr[BANK_BITS-1:0])));
    assign rdata_ext = WORD_LENGTH'(load_extend(MAX_WORD'(b_word), mask_q,
                                                LSB_BITS'(lsb_q), uns_q));

    for (genvar k = 0; k < NUM_BANKS; k++) begin : g_lane
        riscv_bram_lane #(
            .DEPTH  (DEPTH),
            .ADDR_W (ROW_BITS)
        ) u_lane (
            .clk     (clk),
            .a_en    (i_req),
            .a_addr  (i_row),
            .a_rdata (a_word[8*k +: 8]),
            .b_en    (accept),
            .b_we    (accept && d_we && !d_bad && lane_en[k]),
            .b_addr  (d_row),
            .b_wdata (wdata_rep[8*k +: 8]),
            .b_rdata (b_word[8*k +: 8])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_rvalid_q <= 1'b0;
            i_err_q    <= 1'b0;
        end else begin
            i_rvalid_q <= i_req;
            i_err_q    <= i_req && i_bad;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            d_ready_q  <= 1'b1;
            d_rvalid_q <= 1'b0;
            d_err_q    <= 1'b0;
            load_q     <= 1'b0;
            uns_q      <= 1'b0;
            mask_q     <= MASK_X;
            lsb_q      <= '0;
            rdata_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        d_ready_q <= 1'b0;
                        d_err_q   <= d_bad;
                        load_q    <= !d_we;
                        uns_q     <= d_unsigned;
                        mask_q    <= d_mask;
                        lsb_q     <= d_addr[BANK_BITS-1:0];
                        if (!d_we && READ_LATENCY == 2) begin
                            state <= WAIT;
                        end else begin
                            state      <= RESP;
                            d_rvalid_q <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    state      <= RESP;
                    d_rvalid_q <= 1'b1;
                    rdata_q    <= rdata_ext;
                end
                RESP: begin
                    if (d_rready) begin
                        state      <= IDLE;
                        d_rvalid_q <= 1'b0;
                        d_ready_q  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Lane RAMs are not reset, so read data is gated to zero outside a clean response.
    assign i_rvalid = i_rvalid_q;
    assign i_err    = i_err_q;
    assign i_inst   = (i_rvalid_q && !i_err_q) ? a_word : '0;
    assign d_ready  = d_ready_q;
    assign d_rvalid = d_rvalid_q;
    assign d_err    = d_err_q;
    assign d_rdata  = (d_rvalid_q && load_q && !d_err_q)
                    ? ((READ_LATENCY == 2) ? rdata_q : rdata_ext) : '0;

endmodule

// File: tb/tb_riscv_mem_banked.sv
// Bench for riscv_mem_banked: one instance per read latency, directed and
// random traffic compared against a flat byte-array memory model.
module tb_riscv_mem_banked;
    import riscv_pkg::*;

    localparam int unsigned NUM_MEM = 16384;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]        i_req, i_rvalid, i_err;
    logic [1:0][31:0]  i_addr, i_inst;
    logic [1:0]        d_req, d_ready, d_we, d_unsigned, d_rvalid, d_rready, d_err;
    logic [1:0][31:0]  d_addr, d_wdata, d_rdata;
    MASK_SEL           d_mask [2];

    logic [7:0] model [2][NUM_MEM];
    int n_checks = 0;
    int n_err = 0;

    riscv_mem_banked #(.WORD_LENGTH(32), .ADDR_LENGTH(32), .NUM_MEM(NUM_MEM), .READ_LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req[0]), .i_addr(i_addr[0]), .i_rvalid(i_rvalid[0]), .i_inst(i_inst[0]), .i_err(i_err[0]),
        .d_req(d_req[0]), .d_ready(d_ready[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
        .d_mask(d_mask[0]), .d_unsigned(d_unsigned[0]), .d_rvalid(d_rvalid[0]), .d_rready(d_rready[0]),
        .d_rdata(d_rdata[0]), .d_err(d_err[0])
    );

    riscv_mem_banked #(.WORD_LENGTH(32), .ADDR_LENGTH(32), .NUM_MEM(NUM_MEM), .READ_LATENCY(2)) u_dut_l2 (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req[1]), .i_addr(i_addr[1]), .i_rvalid(i_rvalid[1]), .i_inst(i_inst[1]), .i_err(i_err[1]),
        .d_req(d_req[1]), .d_ready(d_ready[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
        .d_mask(d_mask[1]), .d_unsigned(d_unsigned[1]), .d_rvalid(d_rvalid[1]), .d_rready(d_rready[1]),
        .d_rdata(d_rdata[1]), .d_err(d_err[1])
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int size_of(input MASK_SEL m);
        return (m == MASK_B) ? 1 : (m == MASK_H) ? 2 : 4;
    endfunction

    function automatic bit model_err(input logic [31:0] addr, input MASK_SEL m);
        return (addr >= NUM_MEM) || ((addr % size_of(m)) != 0);
    endfunction

    function automatic logic [31:0] model_load(input int p, input logic [31:0] addr,
                                               input MASK_SEL m, input bit uns);
        int n;
        logic [31:0] v;
        n = size_of(m);
        v = '0;
        for (int i = 0; i < n; i++) v = v | (32'(model[p][addr + i]) << (8 * i));
        if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    // One data-port transaction with optional concurrent fetch and a held response.
    task automatic do_txn(input int p, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          input MASK_SEL m, input bit uns, input int hold,
                          input bit fetch_en, input logic [31:0] faddr);
        bit          exp_err, f_err;
        logic [31:0] exp_rd, exp_inst;
        int          exp_lat, lat;
        exp_err  = model_err(addr, m);
        exp_rd   = (we || exp_err) ? 32'h0 : model_load(p, addr, m, uns);
        exp_lat  = we ? 1 : p + 1;
        f_err    = model_err(faddr, MASK_X);
        exp_inst = f_err ? 32'h0 : model_load(p, faddr, MASK_X, 1'b1);

        @(posedge clk); #1;
        d_req[p] = 1'b1; d_we[p] = we; d_addr[p] = addr; d_wdata[p] = wdata;
        d_mask[p] = m; d_unsigned[p] = uns;
        i_req[p] = fetch_en; i_addr[p] = faddr;
        @(negedge clk);
        check($sformatf("dut%0d ready_before_accept", p), d_ready[p], 1);
        @(posedge clk);
        if (we && !exp_err)
            for (int i = 0; i < size_of(m); i++) model[p][addr + i] = wdata[8*i +: 8];
        #1;
        d_req[p] = 1'b0; i_req[p] = 1'b0;

        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (fetch_en && lat == 1) begin
                check($sformatf("dut%0d fetch_rvalid", p), i_rvalid[p], 1);
                check($sformatf("dut%0d fetch_err", p), i_err[p], f_err);
                check($sformatf("dut%0d fetch_inst @%0h", p, faddr), i_inst[p], exp_inst);
            end
        end while (!d_rvalid[p] && lat < 6);
        check($sformatf("dut%0d latency @%0h", p, addr), lat, exp_lat);
        if (!d_rvalid[p]) return;
        check($sformatf("dut%0d d_err @%0h", p, addr), d_err[p], exp_err);
        check($sformatf("dut%0d d_rdata @%0h", p, addr), d_rdata[p], exp_rd);
        check($sformatf("dut%0d ready_in_resp", p), d_ready[p], 0);

        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            d_req[p] = 1'b1; d_we[p] = 1'b1; d_addr[p] = 32'h100;
            d_wdata[p] = 32'hCAFE_F00D; d_mask[p] = MASK_X;
            @(negedge clk);
            check($sformatf("dut%0d hold_rvalid", p), d_rvalid[p], 1);
            check($sformatf("dut%0d hold_rdata", p), d_rdata[p], exp_rd);
            check($sformatf("dut%0d hold_ready", p), d_ready[p], 0);
        end

        @(posedge clk); #1;
        d_rready[p] = 1'b1;
        @(posedge clk); #1;
        d_rready[p] = 1'b0; d_req[p] = 1'b0;
        @(negedge clk);
        check($sformatf("dut%0d rvalid_after_hs", p), d_rvalid[p], 0);
        check($sformatf("dut%0d ready_after_hs", p), d_ready[p], 1);
    endtask

    task automatic fetch(input int p, input logic [31:0] addr);
        bit          f_err;
        logic [31:0] exp_inst;
        f_err    = model_err(addr, MASK_X);
        exp_inst = f_err ? 32'h0 : model_load(p, addr, MASK_X, 1'b1);
        @(posedge clk); #1;
        i_req[p] = 1'b1; i_addr[p] = addr;
        @(posedge clk); #1;
        i_req[p] = 1'b0;
        @(negedge clk);
        check($sformatf("dut%0d fetch_rvalid @%0h", p, addr), i_rvalid[p], 1);
        check($sformatf("dut%0d fetch_err @%0h", p, addr), i_err[p], f_err);
        check($sformatf("dut%0d fetch_inst @%0h", p, addr), i_inst[p], exp_inst);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        i_req = '0; i_addr = '0; d_req = '0; d_we = '0; d_addr = '0; d_wdata = '0;
        d_unsigned = '0; d_rready = '0;
        d_mask[0] = MASK_X; d_mask[1] = MASK_X;

        #2;
        for (int p = 0; p < 2; p++) begin
            check($sformatf("dut%0d rst i_rvalid", p), i_rvalid[p], 0);
            check($sformatf("dut%0d rst i_err", p), i_err[p], 0);
            check($sformatf("dut%0d rst i_inst", p), i_inst[p], 0);
            check($sformatf("dut%0d rst d_rvalid", p), d_rvalid[p], 0);
            check($sformatf("dut%0d rst d_err", p), d_err[p], 0);
            check($sformatf("dut%0d rst d_rdata", p), d_rdata[p], 0);
        end
        #21 rst_n = 1'b1;
        @(negedge clk);
        check("dut0 ready_after_reset", d_ready[0], 1);
        check("dut1 ready_after_reset", d_ready[1], 1);

        // Reset while the latency-2 instance sits in WAIT: no response may follow.
        @(posedge clk); #1;
        d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 32'h40; d_mask[1] = MASK_X;
        @(posedge clk); #1;
        d_req[1] = 1'b0;
        check("dut1 ready_in_wait", d_ready[1], 0);
        #1 rst_n = 1'b0;
        #1 check("dut1 rvalid_in_reset", d_rvalid[1], 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("dut1 no_resp_after_reset", d_rvalid[1], 0);
            check("dut1 ready_after_midreset", d_ready[1], 1);
        end

        for (int p = 0; p < 2; p++) begin
            do_txn(p, 1, 32'h200, 32'h0000_0013, MASK_X, 0, 0, 0, 0);
            do_txn(p, 1, 32'h100, 32'hDEAD_BEEF, MASK_X, 0, 0, 0, 0);
            do_txn(p, 0, 32'h100, 0, MASK_X, 0, 0, 0, 0);
            do_txn(p, 1, 32'h103, 32'h0000_0080, MASK_B, 0, 0, 0, 0);
            do_txn(p, 0, 32'h103, 0, MASK_B, 0, 0, 0, 0);
            do_txn(p, 0, 32'h103, 0, MASK_B, 1, 0, 0, 0);
            do_txn(p, 0, 32'h100, 0, MASK_X, 0, 0, 0, 0);
            do_txn(p, 0, 32'h101, 0, MASK_H, 0, 0, 0, 0);
            do_txn(p, 1, 32'h102, 32'h5555_AAAA, MASK_X, 0, 0, 0, 0);
            do_txn(p, 0, 32'h100, 0, MASK_X, 0, 0, 0, 0);
            do_txn(p, 0, NUM_MEM, 0, MASK_X, 0, 0, 0, 0);
            do_txn(p, 0, 32'h102, 0, MASK_H, 0, 5, 0, 0);
            do_txn(p, 0, 32'h100, 0, MASK_X, 0, 0, 0, 0);
            do_txn(p, 1, 32'h200, 32'h1234_5678, MASK_X, 0, 0, 1, 32'h200);
            fetch(p, 32'h200);
            fetch(p, 32'h202);
            fetch(p, NUM_MEM);
        end

        for (int p = 0; p < 2; p++) begin
            for (int w = 0; w < 16; w++)
                do_txn(p, 1, 32'h300 + 4 * w, $urandom, MASK_X, 0, 0, 0, 0);
            for (int n = 0; n < 80; n++) begin
                logic [31:0] a, fa;
                MASK_SEL     m;
                a  = ($urandom_range(0, 9) == 0) ? NUM_MEM - 4 + $urandom_range(0, 11)
                                                 : 32'h300 + $urandom_range(0, 63);
                fa = 32'h300 + $urandom_range(0, 63);
                case ($urandom_range(0, 2))
                    0:       m = MASK_B;
                    1:       m = MASK_H;
                    default: m = MASK_X;
                endcase
                do_txn(p, 1'($urandom_range(0, 1)), a, $urandom, m, 1'($urandom_range(0, 1)),
                       $urandom_range(0, 2), 1'($urandom_range(0, 1)), fa);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
